// File: rtl/yangmips_timer.sv
`default_nettype none
// ============================================================================
// Module   : yangmips_timer
// Brief    : Memory-mapped count/compare timer with prescaler, auto-reload
//            and a level interrupt for the yangmips SOPC data bus.
// Revision : 1.0 - initial release
// ============================================================================
module yangmips_timer #(
  parameter int CNT_W = 32   // width of COUNT, COMPARE, PRESCALE (must be <= 32)
) (
  input  logic        clk,
  input  logic        rst,          // synchronous, active-low
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        timer_int_o
);

  // Word index of each register (addr_i[4:2])
  localparam logic [2:0] c_IDX_COUNT    = 3'd0;
  localparam logic [2:0] c_IDX_COMPARE  = 3'd1;
  localparam logic [2:0] c_IDX_CTRL     = 3'd2;
  localparam logic [2:0] c_IDX_STATUS   = 3'd3;
  localparam logic [2:0] c_IDX_PRESCALE = 3'd4;

  logic [CNT_W-1:0] count_q,    count_d;
  logic [CNT_W-1:0] compare_q,  compare_d;
  logic [CNT_W-1:0] prescale_q, prescale_d;
  logic [CNT_W-1:0] pre_cnt_q,  pre_cnt_d;
  logic [2:0]       ctrl_q,     ctrl_d;      // {IE, AR, EN}
  logic             pend_q,     pend_d;
  logic [31:0]      data_q,     data_d;

  logic [31:0] count_ext, compare_ext, prescale_ext, rd_data;
  logic [2:0]  idx;
  logic        wr, rd, tick, match;

  // Byte-lane offset bits are not decoded
  logic w_unused_addr;
  assign w_unused_addr = ^addr_i[1:0];

  // Merge write data into an existing word under the byte enables
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // Zero-extend the counter-width registers onto the 32-bit bus
  always_comb begin
    count_ext    = '0;
    compare_ext  = '0;
    prescale_ext = '0;
    count_ext[CNT_W-1:0]    = count_q;
    compare_ext[CNT_W-1:0]  = compare_q;
    prescale_ext[CNT_W-1:0] = prescale_q;
  end

  // Bus decode, prescaler, count/compare and register next-state logic
  always_comb begin
    idx   = addr_i[4:2];
    wr    = ce_i & we_i;
    rd    = ce_i & ~we_i;
    tick  = ctrl_q[0] && (pre_cnt_q == prescale_q);
    match = (count_q == compare_q);

    // Prescaler: cleared by disable, by reconfiguration, and on every tick
    if (wr && (idx == c_IDX_CTRL || idx == c_IDX_PRESCALE)) pre_cnt_d = '0;
    else if (!ctrl_q[0] || tick)                            pre_cnt_d = '0;
    else                                                    pre_cnt_d = pre_cnt_q + CNT_W'(1);

    // Tick update of COUNT; a software write in the same cycle wins
    count_d = count_q;
    if (tick) count_d = (match && ctrl_q[1]) ? '0 : count_q + CNT_W'(1);
    if (wr && idx == c_IDX_COUNT) count_d = CNT_W'(be_merge(count_ext, data_i, sel_i));

    compare_d = compare_q;
    if (wr && idx == c_IDX_COMPARE) compare_d = CNT_W'(be_merge(compare_ext, data_i, sel_i));

    prescale_d = prescale_q;
    if (wr && idx == c_IDX_PRESCALE) prescale_d = CNT_W'(be_merge(prescale_ext, data_i, sel_i));

    ctrl_d = ctrl_q;
    if (wr && idx == c_IDX_CTRL && sel_i[0]) ctrl_d = data_i[2:0];

    // A match sets PEND even if software clears it in the same cycle
    pend_d = pend_q;
    if (wr && idx == c_IDX_STATUS && sel_i[0] && data_i[0]) pend_d = 1'b0;
    if (tick && match) pend_d = 1'b1;

    case (idx)
      c_IDX_COUNT:    rd_data = count_ext;
      c_IDX_COMPARE:  rd_data = compare_ext;
      c_IDX_CTRL:     rd_data = {29'd0, ctrl_q};
      c_IDX_STATUS:   rd_data = {31'd0, pend_q};
      c_IDX_PRESCALE: rd_data = prescale_ext;
      default:        rd_data = 32'd0;
    endcase
    data_d = rd ? rd_data : data_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      compare_q  <= '1;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      ctrl_q     <= 3'd0;
      pend_q     <= 1'b0;
      data_q     <= 32'd0;
    end else begin
      count_q    <= count_d;
      compare_q  <= compare_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      ctrl_q     <= ctrl_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
    end
  end

  assign data_o      = data_q;
  assign timer_int_o = pend_q & ctrl_q[2];

endmodule
`default_nettype wire

// File: tb/tb_yangmips_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_yangmips_timer
// Brief    : Scoreboard bench for yangmips_timer: directed scenarios followed
//            by random bus traffic, checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_yangmips_timer;

  logic        clk = 1'b0;
  logic        rst, ce_i, we_i;
  logic [4:0]  addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i, data_o;
  logic        timer_int_o;

  always #5 clk = ~clk;

  yangmips_timer #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .data_i(data_i), .data_o(data_o), .timer_int_o(timer_int_o)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd_q[$];   // expected read data, one per read (or reset) cycle
  logic        int_q[$];  // expected interrupt level, one per cycle
  logic        rd_seen = 1'b0;

  // Behavioural register file
  logic [31:0] m_count, m_compare, m_prescale;
  logic [31:0] m_phase;   // clocks elapsed in the current prescale period
  logic [2:0]  m_ctrl;
  logic        m_pend;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endfunction

  // Advance the model by one clock edge using the inputs presented at it
  task automatic model_edge();
    logic [31:0] rv, nxt_count;
    logic        is_tick, hit;
    int          a;
    if (!rst) begin
      m_count = 0; m_compare = 32'hFFFF_FFFF; m_prescale = 0;
      m_phase = 0; m_ctrl = 0; m_pend = 0;
      rd_q.push_back(32'd0);
      int_q.push_back(1'b0);
      return;
    end
    a = int'(addr_i[4:2]);
    case (a)
      0: rv = m_count;
      1: rv = m_compare;
      2: rv = {29'd0, m_ctrl};
      3: rv = {31'd0, m_pend};
      4: rv = m_prescale;
      default: rv = 0;
    endcase
    if (ce_i && !we_i) rd_q.push_back(rv);

    // The count advances on the last clock of each (PRESCALE+1)-clock period
    is_tick = m_ctrl[0] && (m_phase == m_prescale);
    hit     = is_tick && (m_count == m_compare);
    nxt_count = m_count;
    if (is_tick) nxt_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;

    if (!m_ctrl[0] || is_tick) m_phase = 0;
    else                       m_phase = m_phase + 1;

    if (ce_i && we_i) begin
      case (a)
        0: nxt_count  = merge(m_count, data_i, sel_i);
        1: m_compare  = merge(m_compare, data_i, sel_i);
        2: begin
             if (sel_i[0]) m_ctrl = data_i[2:0];
             m_phase = 0;
           end
        3: if (sel_i[0] && data_i[0]) m_pend = 1'b0;
        4: begin
             m_prescale = merge(m_prescale, data_i, sel_i);
             m_phase = 0;
           end
        default: ;
      endcase
    end
    if (hit) m_pend = 1'b1;
    m_count = nxt_count;
    int_q.push_back(m_pend & m_ctrl[2]);
  endtask

  // Note which edges should produce fresh data_o
  always @(posedge clk) rd_seen <= (ce_i && !we_i) || !rst;

  // Monitor: pop expectations whenever the DUT presents a response
  always @(negedge clk) begin
    logic        ei;
    logic [31:0] ed;
    if (int_q.size() > 0) begin
      ei = int_q.pop_front();
      chk("timer_int_o", {31'd0, timer_int_o}, {31'd0, ei});
    end
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        chk("rd_underflow", 32'd1, 32'd0);
      end else begin
        ed = rd_q.pop_front();
        chk("data_o", data_o, ed);
      end
    end
  end

  task automatic cyc(input logic r, input logic c, input logic w, input logic [4:0] a,
                     input logic [3:0] s, input logic [31:0] d);
    rst = r; ce_i = c; we_i = w; addr_i = a; sel_i = s; data_i = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, 1'b1, a, 4'hF, d);
  endtask
  task automatic rd(input logic [4:0] a);
    cyc(1'b1, 1'b1, 1'b0, a, 4'h0, 32'd0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 5'd0, 4'h0, 32'd0);
  endtask
  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
    int          op;

    // Reset values
    reset_cycles(5);
    for (int i = 0; i < 6; i++) rd(5'(4 * i));

    // Periodic interrupt with auto-reload
    wr(5'h04, 32'd3);
    wr(5'h10, 32'd0);
    wr(5'h08, 32'h7);
    for (int i = 0; i < 7; i++) rd(5'h00);
    wr(5'h0C, 32'd1);
    for (int i = 0; i < 7; i++) rd(5'h00);

    // Prescaler and one-shot
    wr(5'h08, 32'h0);
    wr(5'h00, 32'd0);
    wr(5'h0C, 32'd1);
    wr(5'h10, 32'd4);
    wr(5'h04, 32'd2);
    wr(5'h08, 32'h5);
    for (int i = 0; i < 24; i++) rd((i % 2 == 0) ? 5'h00 : 5'h0C);

    // Collisions: COUNT write during a tick, W1C during a match
    wr(5'h08, 32'h0);
    wr(5'h10, 32'd0);
    wr(5'h04, 32'd3);
    wr(5'h08, 32'h7);
    idle(1);
    wr(5'h00, 32'h10);
    rd(5'h00);
    wr(5'h0C, 32'd1);
    wr(5'h00, 32'd0);
    idle(3);
    wr(5'h0C, 32'd1);
    rd(5'h0C);
    rd(5'h0C);

    // Wrap without a false match
    wr(5'h08, 32'h0);
    wr(5'h10, 32'd0);
    wr(5'h04, 32'd5);
    wr(5'h0C, 32'd1);
    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h08, 32'h5);
    for (int i = 0; i < 10; i++) rd((i % 3 == 2) ? 5'h0C : 5'h00);

    // Byte enables, then reset while PEND is set
    reset_cycles(1);
    cyc(1'b1, 1'b1, 1'b1, 5'h04, 4'b0101, 32'hAABB_CCDD);
    rd(5'h04);
    wr(5'h04, 32'd2);
    wr(5'h08, 32'h7);
    idle(5);
    rd(5'h0C);
    reset_cycles(1);
    for (int i = 0; i < 6; i++) rd(5'(4 * i));

    // Random bus traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      op = int'($urandom_range(0, 9));
      a  = {3'($urandom_range(0, 7)), 2'($urandom)};
      s  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      case (a[4:2])
        3'd0:    d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                 : 32'($urandom_range(0, 8));
        3'd1:    d = 32'($urandom_range(0, 12));
        3'd4:    d = 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 199) == 0) cyc(1'b0, 1'b0, 1'b0, a, s, d);
      else if (op < 4)                 idle(1);
      else if (op < 7)                 cyc(1'b1, 1'b1, 1'b0, a, s, d);
      else                             cyc(1'b1, 1'b1, 1'b1, a, s, d);
    end

    idle(3);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
